// File: rtl/jedro_ram_arbiter.sv
// Round-robin arbiter sharing one bytewrite RAM between the fetch (m0)
// and load/store (m1) ports, with one outstanding transaction and a watchdog.
module jedro_ram_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_stb,
    input  logic [3:0]            m0_we,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_stb,
    input  logic [3:0]            m1_we,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  s_stb,
    output logic [3:0]            s_we,
    output logic [DATA_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_ack,
    input  logic                  s_err,

    output logic                  timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TLIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic       grant_nxt;
    logic       last;
    logic       last_nxt;
    logic [7:0] tcnt;
    logic [7:0] tcnt_nxt;

    logic busy;
    logic expired;
    logic fin_ack;
    logic fin_err;
    logic done;

    // Reset also masks the outputs so an abandoned transaction never
    // completes toward a master in the reset cycle.
    always_comb begin
        busy    = (state == BUSY) && !rst_i;
        expired = busy && !s_ack && !s_err && (tcnt == TLIMIT);
        fin_err = busy && (s_err || expired);
        fin_ack = busy && s_ack && !s_err;
        done    = fin_err || fin_ack;
    end

    always_comb begin
        s_stb     = 1'b0;
        s_we      = 4'h0;
        s_addr    = '0;
        s_wdata   = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        timeout_o = expired;
        if (busy) begin
            s_stb = 1'b1;
            if (grant) begin
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_we    = m0_we;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
        if (grant) begin
            m1_ack = fin_ack;
            m1_err = fin_err;
            if (fin_ack) m1_rdata = s_rdata;
        end else begin
            m0_ack = fin_ack;
            m0_err = fin_err;
            if (fin_ack) m0_rdata = s_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        tcnt_nxt  = tcnt;
        unique case (state)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    state_nxt = BUSY;
                    tcnt_nxt  = 8'd0;
                    // On a tie the master not served last wins.
                    if (m0_stb && m1_stb) grant_nxt = ~last;
                    else                  grant_nxt = m1_stb;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt = IDLE;
                    last_nxt  = grant;
                    tcnt_nxt  = 8'd0;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            tcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

endmodule
